rv32imf_prefetch_fifo: RTL and testbench
========================================

# rv32imf_prefetch_fifo

Instruction prefetch buffer placed directly downstream of the prefetch controller in the RV32IMF fetch path. It stores 32-bit fetch responses pushed by the controller and presents the oldest entry to the instruction aligner. It reports occupancy back to the controller and supports full flush (branch) and flush-all-but-head (hardware-loop jump).

## Interface
- DEPTH, 4, number of 32-bit entries; legal range is 2..16 and need not be a power of two.
- FIFO_ADDR_DEPTH, $clog2(DEPTH), pointer width.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- push_i  in  1  write data_i this cycle.
- data_i  in  32  fetched instruction word.
- pop_i  in  1  consume head entry.
- flush_i  in  1  discard all entries.
- flush_but_first_i  in  1  discard all entries except the head.
- data_o  out  32  head entry.
- empty_o  out  1  no valid entry.
- full_o  out  1  cnt_o == DEPTH.
- cnt_o  out  FIFO_ADDR_DEPTH+1  number of valid entries, 0..DEPTH.
- overflow_o  out  1  sticky error: a push was attempted while full.

## Operation
- State consists of:
  - storage mem[DEPTH] of 32 bits;
  - rd_ptr and wr_ptr, FIFO_ADDR_DEPTH bits each;
  - cnt_q, FIFO_ADDR_DEPTH+1 bits;
  - overflow_q.
- Pointer advance: ptr == DEPTH-1 wraps to 0; otherwise ptr+1. Never rely on natural binary wrap.
- Per-cycle priority, highest first:
  1. rst
  2. flush_i
  3. flush_but_first_i
  4. push/pop
- flush_i: rd_ptr = wr_ptr = 0, cnt = 0. A push or pop in the same cycle is dropped. overflow_q is unchanged.
- flush_but_first_i:
  - Non-empty and pop_i = 0: wr_ptr = next(rd_ptr), cnt = 1, head data kept.
  - Non-empty and pop_i = 1: behaves exactly as flush_i.
  - Empty: no effect. A push in the same cycle is dropped.
- push only (not full): mem[wr_ptr] = data_i, wr_ptr advances, cnt +1.
- push while full:
  - Without a pop: the word is dropped and overflow_q sets.
  - With a pop in the same cycle: both are accepted, and cnt stays at DEPTH.
- pop only (not empty): rd_ptr advances, cnt −1. A pop while empty is ignored.
- push and pop, 0 < cnt < DEPTH: both pointers advance, cnt is unchanged.
- push and pop while empty (fall-through disabled): the push is stored, the pop is ignored, cnt = 1.
- data_o = mem[rd_ptr], combinational from storage. It is undefined-but-stable (the last stored value) when empty.
- Status outputs: empty_o = (cnt_q == 0); full_o = (cnt_q == DEPTH); cnt_o = cnt_q.

## Timing
- All outputs are registered-state derived. Exception: fall-through mode (see Configuration).
- Push-to-visible latency: 1 cycle. A word pushed at edge N appears on data_o, with empty_o low, after edge N.
- Pop takes effect at the edge. The next head appears the following cycle.
- Reset values: cnt_o = 0, empty_o = 1, full_o = 0, overflow_o = 0, data_o = 0 (storage cleared on reset).
- Reset asserted mid-operation wins over every other input in that cycle.
- overflow_o clears only on rst.

## Configuration
- Macro: RV32IMF_PREFETCH_FIFO_FALL_THROUGH_EN.
- Defined: when empty and push_i = 1 (no flush):
  - data_o = data_i and empty_o = 0 combinationally in the same cycle.
  - If pop_i is also 1, the word is consumed without being stored: pointers and cnt are unchanged.
  - cnt_o and full_o stay register-based.
- Not defined: data_o and empty_o depend on state only. An empty push+pop stores the word.

## Structure
- rv32imf_pkg receives:
  - localparam PREFETCH_FIFO_DEPTH = 4;
  - a typedef for the 32-bit instruction word, fetch_word_t.
- The pointer-increment-with-wrap function is local to the module.
- No sub-module; storage is a flat register array.

## Test plan
- Reset, then idle → cnt_o = 0, empty_o = 1, full_o = 0, overflow_o = 0.
- Push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) → full_o = 1, cnt_o = 4.
  - Fifth push of 0x55 without pop → dropped, overflow_o = 1.
  - Then four pops → outputs 0x11..0x44 in order.
- DEPTH=3, repeat push/pop 10 times → pointers wrap correctly; data_o order matches a scoreboard.
- Fill with 0xA0, 0xA1, 0xA2, then pulse flush_but_first_i → cnt_o = 1, data_o = 0xA0.
  - Then push 0xB0 and pop → data_o = 0xB0.
- cnt_o = 2 with flush_i, push_i and pop_i all high → cnt_o = 0, empty_o = 1, pushed word lost.
- Empty FIFO with push 0xC0 and pop in the same cycle:
  - Macro defined → data_o = 0xC0 that cycle, cnt_o stays 0.
  - Macro undefined → cnt_o = 1, data_o = 0xC0 next cycle.

Source files
------------

// File: rtl/rv32imf_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : rv32imf_pkg                                             |
// | Description : Shared types and constants for the RV32IMF fetch path.  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package rv32imf_pkg;

   // Default number of entries in the instruction prefetch buffer
   localparam int PREFETCH_FIFO_DEPTH = 4;

   // One fetched 32-bit instruction word
   typedef logic [31:0] fetch_word_t;

endpackage : rv32imf_pkg
`default_nettype wire

// File: rtl/rv32imf_prefetch_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : rv32imf_prefetch_fifo                                   |
// | Description : Instruction prefetch buffer between the prefetch        |
// |               controller and the instruction aligner. Supports full   |
// |               flush and flush-all-but-head. Optional same-cycle       |
// |               fall-through on an empty buffer is enabled by the macro |
// |               RV32IMF_PREFETCH_FIFO_FALL_THROUGH_EN.                  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module rv32imf_prefetch_fifo
   import rv32imf_pkg::*;
#(
   parameter int DEPTH           = PREFETCH_FIFO_DEPTH,
   parameter int FIFO_ADDR_DEPTH = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fetch_word_t              data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic                     flush_but_first_i,
   output fetch_word_t              data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [FIFO_ADDR_DEPTH:0] cnt_o,
   output logic                     overflow_o
);

   localparam logic [FIFO_ADDR_DEPTH:0]   CNT_FULL = (FIFO_ADDR_DEPTH+1)'(DEPTH);
   localparam logic [FIFO_ADDR_DEPTH:0]   CNT_ONE  = (FIFO_ADDR_DEPTH+1)'(1);
   localparam logic [FIFO_ADDR_DEPTH-1:0] PTR_LAST = FIFO_ADDR_DEPTH'(DEPTH-1);
   localparam logic [FIFO_ADDR_DEPTH-1:0] PTR_ONE  = FIFO_ADDR_DEPTH'(1);

   // Explicit wrap so that non-power-of-two depths work
   function automatic logic [FIFO_ADDR_DEPTH-1:0] ptr_next(input logic [FIFO_ADDR_DEPTH-1:0] p);
      if (p == PTR_LAST) begin
         ptr_next = '0;
      end else begin
         ptr_next = p + PTR_ONE;
      end
   endfunction

   fetch_word_t                mem [DEPTH];
   logic [FIFO_ADDR_DEPTH-1:0] rd_ptr;
   logic [FIFO_ADDR_DEPTH-1:0] wr_ptr;
   logic [FIFO_ADDR_DEPTH:0]   cnt_q;
   logic                       overflow_q;

   logic is_empty;
   logic is_full;
   logic ft_bypass;
   logic do_push;
   logic do_pop;

   // Occupancy decode and push/pop acceptance for the plain push/pop case
   always_comb begin
      is_empty  = (cnt_q == '0);
      is_full   = (cnt_q == CNT_FULL);
`ifdef RV32IMF_PREFETCH_FIFO_FALL_THROUGH_EN
      // Empty buffer forwards the incoming word straight to the aligner
      ft_bypass = is_empty & push_i & ~flush_i & ~flush_but_first_i;
`else
      ft_bypass = 1'b0;
`endif
      // A full buffer still accepts a push when the head leaves that cycle;
      // a bypassed word that is popped at once never enters storage
      do_push   = push_i & (~is_full | pop_i) & ~(ft_bypass & pop_i);
      do_pop    = pop_i & ~is_empty;
   end

   // Storage, pointers, occupancy and sticky overflow; rst > flush > flush_but_first > push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else if (flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
      end else if (flush_but_first_i) begin
         if (!is_empty) begin
            if (pop_i) begin
               // Head is consumed as well, so nothing survives
               rd_ptr <= '0;
               wr_ptr <= '0;
               cnt_q  <= '0;
            end else begin
               wr_ptr <= ptr_next(rd_ptr);
               cnt_q  <= CNT_ONE;
            end
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         if (do_push && !do_pop) begin
            cnt_q <= cnt_q + CNT_ONE;
         end else if (!do_push && do_pop) begin
            cnt_q <= cnt_q - CNT_ONE;
         end
         if (push_i && is_full && !pop_i) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Head presentation and status derived from registered state
   always_comb begin
      data_o     = ft_bypass ? data_i : mem[rd_ptr];
      empty_o    = is_empty & ~ft_bypass;
      full_o     = is_full;
      cnt_o      = cnt_q;
      overflow_o = overflow_q;
   end

endmodule : rv32imf_prefetch_fifo
`default_nettype wire

// File: tb/tb_rv32imf_prefetch_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_rv32imf_prefetch_fifo                                |
// | Description : Scoreboard bench for rv32imf_prefetch_fifo; runs a      |
// |               DEPTH=4 and a DEPTH=3 instance from shared stimulus.    |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_rv32imf_prefetch_fifo;

   typedef logic [31:0] word_t;
   typedef word_t wq_t[$];
   typedef struct {
      int    cnt;
      bit    empty;
      bit    full;
      bit    ovf;
      bit    dchk;
      word_t data;
   } view_t;

`ifdef RV32IMF_PREFETCH_FIFO_FALL_THROUGH_EN
   localparam bit FT = 1'b1;
`else
   localparam bit FT = 1'b0;
`endif

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  push = 1'b0;
   logic  pop = 1'b0;
   logic  flush = 1'b0;
   logic  fbf = 1'b0;
   word_t din = '0;

   word_t      d4_data, d3_data;
   logic       d4_empty, d4_full, d4_ovf, d3_empty, d3_full, d3_ovf;
   logic [2:0] d4_cnt, d3_cnt;

   always #5 clk = ~clk;

   rv32imf_prefetch_fifo #(.DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .push_i(push), .data_i(din), .pop_i(pop),
      .flush_i(flush), .flush_but_first_i(fbf), .data_o(d4_data),
      .empty_o(d4_empty), .full_o(d4_full), .cnt_o(d4_cnt), .overflow_o(d4_ovf)
   );

   rv32imf_prefetch_fifo #(.DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .push_i(push), .data_i(din), .pop_i(pop),
      .flush_i(flush), .flush_but_first_i(fbf), .data_o(d3_data),
      .empty_o(d3_empty), .full_o(d3_full), .cnt_o(d3_cnt), .overflow_o(d3_ovf)
   );

   // Reference state: contents as a queue (head at index 0), sticky flag,
   // and "nothing stored since reset" so cleared storage can be checked
   wq_t   mq4, mq3;
   bit    mo4 = 0, mo3 = 0, mf4 = 1, mf3 = 1;
   view_t exp4[$], exp3[$];
   int    total = 0;
   int    bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h time=%0t", nm, act, req, $time);
      end
   endtask

   // What the outputs should show this cycle, given state and current inputs
   function automatic view_t make_view(input int d, input wq_t q, input bit o, input bit fr,
                                       input bit ps, input word_t di, input bit fl, input bit fb);
      view_t v;
      bit    ft = FT && (q.size() == 0) && ps && !fl && !fb;
      v.cnt   = q.size();
      v.empty = (q.size() == 0) && !ft;
      v.full  = (q.size() == d);
      v.ovf   = o;
      v.dchk  = 1'b1;
      v.data  = '0;
      if (q.size() > 0)  v.data = q[0];
      else if (ft)       v.data = di;
      else if (!fr)      v.dchk = 1'b0;
      return v;
   endfunction

   // Contents after the coming clock edge, from the buffer's rules
   task automatic model_next(input int d, input wq_t qi, input bit oi, input bit fi,
                             output wq_t qo, output bit oo, output bit fo);
      int n = qi.size();
      qo = qi;
      oo = oi;
      fo = fi;
      if (rst) begin
         qo.delete();
         oo = 1'b0;
         fo = 1'b1;
      end else if (flush) begin
         qo.delete();
      end else if (fbf) begin
         if (n > 0) begin
            word_t h = qi[0];
            qo.delete();
            if (!pop) qo.push_back(h);
         end
      end else if (n == 0) begin
         if (push && !(FT && pop)) begin
            qo.push_back(din);
            fo = 1'b0;
         end
      end else if (n == d) begin
         if (push && pop) begin
            void'(qo.pop_front());
            qo.push_back(din);
            fo = 1'b0;
         end else if (push) begin
            oo = 1'b1;
         end else if (pop) begin
            void'(qo.pop_front());
         end
      end else begin
         if (pop) void'(qo.pop_front());
         if (push) begin
            qo.push_back(din);
            fo = 1'b0;
         end
      end
   endtask

   // One stimulus cycle: drive, record expected outputs, advance the models
   task automatic cyc(input bit r, input bit p, input word_t dv, input bit po,
                      input bit fl, input bit fb);
      @(posedge clk);
      #1;
      rst = r; push = p; din = dv; pop = po; flush = fl; fbf = fb;
      if (!r) begin
         exp4.push_back(make_view(4, mq4, mo4, mf4, p, dv, fl, fb));
         exp3.push_back(make_view(3, mq3, mo3, mf3, p, dv, fl, fb));
      end
      model_next(4, mq4, mo4, mf4, mq4, mo4, mf4);
      model_next(3, mq3, mo3, mf3, mq3, mo3, mf3);
   endtask

   task automatic idle();
      cyc(0, 0, 32'h0, 0, 0, 0);
   endtask

   // Monitor for the DEPTH=4 instance
   always @(negedge clk) begin : mon4
      view_t v;
      if (exp4.size() > 0) begin
         v = exp4.pop_front();
         chk("d4_cnt", 32'(d4_cnt), 32'(v.cnt));
         chk("d4_empty", 32'(d4_empty), 32'(v.empty));
         chk("d4_full", 32'(d4_full), 32'(v.full));
         chk("d4_overflow", 32'(d4_ovf), 32'(v.ovf));
         if (v.dchk) chk("d4_data", d4_data, v.data);
      end
   end

   // Monitor for the DEPTH=3 instance
   always @(negedge clk) begin : mon3
      view_t v;
      if (exp3.size() > 0) begin
         v = exp3.pop_front();
         chk("d3_cnt", 32'(d3_cnt), 32'(v.cnt));
         chk("d3_empty", 32'(d3_empty), 32'(v.empty));
         chk("d3_full", 32'(d3_full), 32'(v.full));
         chk("d3_overflow", 32'(d3_ovf), 32'(v.ovf));
         if (v.dchk) chk("d3_data", d3_data, v.data);
      end
   end

   initial begin
      cyc(1, 0, 32'h0, 0, 0, 0);
      cyc(1, 0, 32'h0, 0, 0, 0);
      idle();
      idle();
      // Fill, overflow, drain
      cyc(0, 1, 32'h11, 0, 0, 0);
      cyc(0, 1, 32'h22, 0, 0, 0);
      cyc(0, 1, 32'h33, 0, 0, 0);
      cyc(0, 1, 32'h44, 0, 0, 0);
      cyc(0, 1, 32'h55, 0, 0, 0);
      idle();
      for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1, 0, 0);
      idle();
      // Flush all but head, then push/pop behind it
      cyc(0, 1, 32'hA0, 0, 0, 0);
      cyc(0, 1, 32'hA1, 0, 0, 0);
      cyc(0, 1, 32'hA2, 0, 0, 0);
      cyc(0, 0, 32'h0, 0, 0, 1);
      idle();
      cyc(0, 1, 32'hB0, 0, 0, 0);
      cyc(0, 0, 32'h0, 1, 0, 0);
      idle();
      // Two entries, then flush with push and pop together
      cyc(0, 1, 32'hD1, 0, 0, 0);
      cyc(0, 0, 32'h0, 0, 1, 0);
      cyc(0, 1, 32'hD2, 0, 0, 0);
      cyc(0, 1, 32'hD3, 0, 0, 0);
      cyc(0, 1, 32'hD4, 1, 1, 0);
      idle();
      // Empty push+pop, empty pop, empty flush_but_first with push
      cyc(0, 1, 32'hC0, 1, 0, 0);
      idle();
      cyc(0, 0, 32'h0, 1, 0, 0);
      cyc(0, 0, 32'h0, 1, 0, 0);
      cyc(0, 1, 32'hE0, 0, 0, 1);
      idle();
      // flush_but_first together with pop on non-empty
      cyc(0, 1, 32'hE1, 0, 0, 0);
      cyc(0, 1, 32'hE2, 0, 0, 0);
      cyc(0, 0, 32'h0, 1, 0, 1);
      idle();
      // Sustained push+pop to walk the pointers around both depths
      cyc(0, 1, 32'hF0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) cyc(0, 1, 32'hF0 + 32'(i), 1, 0, 0);
      cyc(0, 1, 32'hF8, 0, 0, 0);
      cyc(0, 1, 32'hF9, 0, 0, 0);
      cyc(0, 1, 32'hFA, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 32'h100 + 32'(i), 1, 0, 0);
      cyc(0, 1, 32'h1FF, 0, 0, 0);
      // Reset in the middle of traffic wins over a push
      cyc(1, 1, 32'hDEAD, 0, 0, 0);
      idle();
      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, $urandom,
             $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 4);
      end
      idle();
      @(posedge clk);
      @(negedge clk);
      chk("scoreboard_drained4", 32'(exp4.size()), 32'd0);
      chk("scoreboard_drained3", 32'(exp3.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rv32imf_prefetch_fifo
`default_nettype wire
